text_injector: RTL and testbench

TEXT_INJECTOR -- requirements
Module: text_injector

---
 rtl/text_injector_if.sv | 15 +
 rtl/text_injector.sv | 223 ++++++++++++++++++++++
 tb/tb_text_injector.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/text_injector_if.sv
// Loader-side bus of the text injector: byte strobe/abort in, PS/2 key event and status out.
interface text_injector_if;
  logic [7:0]  ascii_byte;
  logic        strobe;
  logic        abort;
  logic        input_wait;
  logic [10:0] ps2_key;
  logic        busy;
  logic        overflow;

  modport master (output ascii_byte, strobe, abort,
                  input  input_wait, ps2_key, busy, overflow);
  modport slave  (input  ascii_byte, strobe, abort,
                  output input_wait, ps2_key, busy, overflow);
endinterface

// File: rtl/text_injector.sv
// Types buffered ASCII text as timed PS/2 set-2 press/release events.
// Define TEXT_INJECTOR_SHIFT_EN to emit left-shift sequences for shifted characters.
module text_injector #(
  parameter int CLK_RATE   = 42954545,
  parameter int FIFO_DEPTH = 16,
  parameter int HOLD_MS    = 40,
  parameter int GAP_MS     = 40,
  parameter int LINE_MS    = 200
) (
  input logic             clk,
  input logic             reset,
  text_injector_if.slave  bus
);
  localparam int TPM    = CLK_RATE / 1000;
  localparam int HOLD_T = TPM * HOLD_MS;
  localparam int GAP_T  = TPM * GAP_MS;
  localparam int LINE_T = GAP_T + TPM * LINE_MS;
  localparam int MAX_T  = (HOLD_T > LINE_T) ? HOLD_T : LINE_T;
  localparam int TW     = $clog2(MAX_T) + 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [7:0] ENTER_CODE = 8'h5A;
  localparam logic [7:0] SHIFT_CODE = 8'h12;

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT_DN, KEY_DN, HOLD, KEY_UP, SHIFT_UP, GAP} state_t;

  typedef struct packed {
    logic [7:0] code;
`ifdef TEXT_INJECTOR_SHIFT_EN
    logic       shift;
`endif
    logic       valid;
  } map_t;

  function automatic map_t map_ascii(input logic [7:0] c);
    map_t m;
    logic [7:0] lc;
    m.code  = 8'h00;
    m.valid = 1'b1;
`ifdef TEXT_INJECTOR_SHIFT_EN
    m.shift = 1'b0;
`endif
    lc = (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
    case (lc)
      8'h61: m.code = 8'h1C;  8'h62: m.code = 8'h32;  8'h63: m.code = 8'h21;
      8'h64: m.code = 8'h23;  8'h65: m.code = 8'h24;  8'h66: m.code = 8'h2B;
      8'h67: m.code = 8'h34;  8'h68: m.code = 8'h33;  8'h69: m.code = 8'h43;
      8'h6A: m.code = 8'h3B;  8'h6B: m.code = 8'h42;  8'h6C: m.code = 8'h4B;
      8'h6D: m.code = 8'h3A;  8'h6E: m.code = 8'h31;  8'h6F: m.code = 8'h44;
      8'h70: m.code = 8'h4D;  8'h71: m.code = 8'h15;  8'h72: m.code = 8'h2D;
      8'h73: m.code = 8'h1B;  8'h74: m.code = 8'h2C;  8'h75: m.code = 8'h3C;
      8'h76: m.code = 8'h2A;  8'h77: m.code = 8'h1D;  8'h78: m.code = 8'h22;
      8'h79: m.code = 8'h35;  8'h7A: m.code = 8'h1A;
      8'h30: m.code = 8'h45;  8'h31: m.code = 8'h16;  8'h32: m.code = 8'h1E;
      8'h33: m.code = 8'h26;  8'h34: m.code = 8'h25;  8'h35: m.code = 8'h2E;
      8'h36: m.code = 8'h36;  8'h37: m.code = 8'h3D;  8'h38: m.code = 8'h3E;
      8'h39: m.code = 8'h46;
      8'h20: m.code = 8'h29;  8'h0A: m.code = ENTER_CODE;
      8'h2C: m.code = 8'h41;  8'h2E: m.code = 8'h49;  8'h2F: m.code = 8'h4A;
      8'h3B: m.code = 8'h4C;  8'h2D: m.code = 8'h4E;  8'h3D: m.code = 8'h55;
`ifdef TEXT_INJECTOR_SHIFT_EN
      // US layout: shifted symbol -> base key
      8'h21: begin m.code = 8'h16; m.shift = 1'b1; end
      8'h22: begin m.code = 8'h52; m.shift = 1'b1; end
      8'h23: begin m.code = 8'h26; m.shift = 1'b1; end
      8'h24: begin m.code = 8'h25; m.shift = 1'b1; end
      8'h25: begin m.code = 8'h2E; m.shift = 1'b1; end
      8'h26: begin m.code = 8'h3D; m.shift = 1'b1; end
      8'h28: begin m.code = 8'h46; m.shift = 1'b1; end
      8'h29: begin m.code = 8'h45; m.shift = 1'b1; end
      8'h2A: begin m.code = 8'h3E; m.shift = 1'b1; end
      8'h2B: begin m.code = 8'h55; m.shift = 1'b1; end
      8'h3A: begin m.code = 8'h4C; m.shift = 1'b1; end
      8'h3C: begin m.code = 8'h41; m.shift = 1'b1; end
      8'h3E: begin m.code = 8'h49; m.shift = 1'b1; end
      8'h3F: begin m.code = 8'h4A; m.shift = 1'b1; end
`endif
      default: m.valid = 1'b0;
    endcase
    return m;
  endfunction

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    code_q, code_d;
  logic [10:0]   ps2_q, ps2_d;
  logic          ovf_q, ovf_d;
`ifdef TEXT_INJECTOR_SHIFT_EN
  logic          shift_q, shift_d;
`endif

  logic       empty, full, push, pop, t_done, ev, ev_press;
  logic [7:0] ev_code;
  map_t       head_map;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push     = bus.strobe && !bus.abort && !full;
  assign t_done   = (timer_q <= TW'(1));
  assign head_map = map_ascii(fifo_mem[rd_ptr_q]);

  always_comb begin
    state_d  = state_q;
    timer_d  = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
    code_d   = code_q;
    ps2_d    = ps2_q;
    pop      = 1'b0;
    ev       = 1'b0;
    ev_press = 1'b0;
    ev_code  = code_q;
`ifdef TEXT_INJECTOR_SHIFT_EN
    shift_d  = shift_q;
`endif
    // Every event loads the timer; the following states count it down so the
    // spacing between events equals the tick count (never less than 1 cycle).
    case (state_q)
      IDLE: if (!empty) state_d = FETCH;
      FETCH: begin
        state_d = IDLE;
        pop     = !empty && !bus.abort;
        if (pop && head_map.valid) begin
          code_d   = head_map.code;
          state_d  = KEY_DN;
          ev       = 1'b1;
          ev_press = 1'b1;
          ev_code  = head_map.code;
          timer_d  = TW'(HOLD_T);
`ifdef TEXT_INJECTOR_SHIFT_EN
          shift_d = head_map.shift;
          if (head_map.shift) begin
            state_d = SHIFT_DN;
            ev_code = SHIFT_CODE;
            timer_d = TW'(GAP_T);
          end
`endif
        end
      end
`ifdef TEXT_INJECTOR_SHIFT_EN
      SHIFT_DN: if (t_done) begin
        state_d  = KEY_DN;
        ev       = 1'b1;
        ev_press = 1'b1;
        timer_d  = TW'(HOLD_T);
      end
      SHIFT_UP: state_d = GAP;
`endif
      KEY_DN: state_d = HOLD;
      HOLD: if (t_done) begin
        state_d = KEY_UP;
        ev      = 1'b1;
        timer_d = (code_q == ENTER_CODE) ? TW'(LINE_T) : TW'(GAP_T);
      end
      KEY_UP: begin
        state_d = GAP;
`ifdef TEXT_INJECTOR_SHIFT_EN
        if (shift_q) begin
          state_d = KEY_UP;
          if (t_done) begin
            state_d = SHIFT_UP;
            ev      = 1'b1;
            ev_code = SHIFT_CODE;
            timer_d = TW'(GAP_T);
          end
        end
`endif
      end
      GAP: if (t_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ev) ps2_d = {~ps2_q[10], ev_press, 1'b0, ev_code};

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (bus.strobe && !bus.abort && full);
    if (bus.abort) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr_q] <= bus.ascii_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      code_q   <= '0;
      ps2_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef TEXT_INJECTOR_SHIFT_EN
      shift_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      code_q   <= code_d;
      ps2_q    <= ps2_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef TEXT_INJECTOR_SHIFT_EN
      shift_q  <= shift_d;
`endif
    end
  end

  assign bus.ps2_key    = ps2_q;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = !empty || (state_q != IDLE);
  assign bus.input_wait = (count_q >= (AW+1)'(FIFO_DEPTH - 2));
endmodule

// File: tb/tb_text_injector.sv
// Directed bench for text_injector: expected key events queued at stimulus time,
// compared in order as the PS/2 toggle bit moves.
module tb_text_injector;
  logic clk = 1'b0;
  logic reset;

  text_injector_if bus();

  text_injector #(
    .CLK_RATE(1000), .FIFO_DEPTH(4), .HOLD_MS(2), .GAP_MS(3), .LINE_MS(5)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic press; logic [7:0] code; } ev_t;

  ev_t  exp_q[$];
  int   ev_cyc_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   busy_fall = 0;
  logic prev_t = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event monitor: every toggle of bit 10 is one event, checked against the scoreboard.
  always @(negedge clk) begin : mon
    ev_t x;
    if (reset) prev_t = 1'b0;
    else if (bus.ps2_key[10] !== prev_t) begin
      prev_t = bus.ps2_key[10];
      ev_cyc_q.push_back(cyc);
      x = '{press: 1'b1, code: 8'hFF};
      if (exp_q.size() != 0) x = exp_q.pop_front();
      chk("event", 32'(bus.ps2_key[9:0]), 32'({x.press, 1'b0, x.code}));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.ascii_byte = b;
    bus.strobe     = 1'b1;
    step();
    bus.strobe     = 1'b0;
  endtask

  task automatic expect_key(input logic [7:0] code);
    exp_q.push_back('{press: 1'b1, code: code});
    exp_q.push_back('{press: 1'b0, code: code});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.busy === 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    busy_fall = cyc;
  endtask

  task automatic wait_events(input string tag, input int n, input int budget);
    int k = 0;
    while (ev_cyc_q.size() < n && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_ev"}, ev_cyc_q.size(), n);
  endtask

  initial begin
    reset          = 1'b1;
    bus.strobe     = 1'b0;
    bus.abort      = 1'b0;
    bus.ascii_byte = 8'h00;
    step();
    step();
    chk("rst_ps2", 32'(bus.ps2_key), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_wait", 32'(bus.input_wait), 32'd0);
    reset = 1'b0;
    step();

    // 'A': press, release 2 cycles later, idle 3 cycles after release
    ev_cyc_q.delete();
    expect_key(8'h1C);
    send(8'h41);
    wait_idle("a", 100);
    chk("a_count", ev_cyc_q.size(), 2);
    if (ev_cyc_q.size() == 2) begin
      chk("a_hold", ev_cyc_q[1] - ev_cyc_q[0], 2);
      chk("a_gap", busy_fall - ev_cyc_q[1], 3);
    end
    chk("a_toggle", 32'(bus.ps2_key[10]), 32'd0);
    chk("a_left", exp_q.size(), 0);

    // '!': shift-wrapped '1' when enabled, silently skipped otherwise
    ev_cyc_q.delete();
`ifdef TEXT_INJECTOR_SHIFT_EN
    exp_q.push_back('{press: 1'b1, code: 8'h12});
    exp_q.push_back('{press: 1'b1, code: 8'h16});
    exp_q.push_back('{press: 1'b0, code: 8'h16});
    exp_q.push_back('{press: 1'b0, code: 8'h12});
`endif
    send(8'h21);
    wait_idle("bang", 200);
`ifdef TEXT_INJECTOR_SHIFT_EN
    chk("bang_count", ev_cyc_q.size(), 4);
    if (ev_cyc_q.size() == 4) begin
      chk("bang_sdn", ev_cyc_q[1] - ev_cyc_q[0], 3);
      chk("bang_hold", ev_cyc_q[2] - ev_cyc_q[1], 2);
      chk("bang_sup", ev_cyc_q[3] - ev_cyc_q[2], 3);
    end
`else
    chk("bang_count", ev_cyc_q.size(), 0);
`endif
    chk("bang_left", exp_q.size(), 0);

    // CR is unmappable
    ev_cyc_q.delete();
    send(8'h0D);
    wait_idle("cr", 50);
    chk("cr_count", ev_cyc_q.size(), 0);

    // LF then 'A': 8 gap cycles, then IDLE and FETCH before the next press
    ev_cyc_q.delete();
    expect_key(8'h5A);
    expect_key(8'h1C);
    send(8'h0A);
    send(8'h41);
    wait_idle("lf", 300);
    chk("lf_count", ev_cyc_q.size(), 4);
    if (ev_cyc_q.size() == 4) begin
      chk("lf_hold", ev_cyc_q[1] - ev_cyc_q[0], 2);
      chk("lf_line", ev_cyc_q[2] - ev_cyc_q[1], 10);
    end
    chk("lf_left", exp_q.size(), 0);

    // 6 back-to-back bytes into a 4-deep FIFO: 'F' is dropped
    ev_cyc_q.delete();
    expect_key(8'h1C);
    expect_key(8'h32);
    expect_key(8'h21);
    expect_key(8'h23);
    expect_key(8'h24);
    send(8'h41);
    chk("ovf_wait_lo", 32'(bus.input_wait), 32'd0);
    send(8'h42);
    chk("ovf_wait_hi", 32'(bus.input_wait), 32'd1);
    send(8'h43);
    send(8'h44);
    send(8'h45);
    chk("ovf_pre", 32'(bus.overflow), 32'd0);
    send(8'h46);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    wait_idle("ovf", 1000);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    chk("ovf_count", ev_cyc_q.size(), 10);
    chk("ovf_left", exp_q.size(), 0);
    reset = 1'b1;
    step();
    chk("ovf_clear", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    step();

    // "AB" with abort during 'A': release still sent, 'B' flushed, strobe ignored
    ev_cyc_q.delete();
    expect_key(8'h1C);
    send(8'h41);
    send(8'h42);
    wait_events("abt", 1, 50);
    bus.abort      = 1'b1;
    bus.strobe     = 1'b1;
    bus.ascii_byte = 8'h43;
    step();
    bus.abort  = 1'b0;
    bus.strobe = 1'b0;
    wait_idle("abt", 200);
    chk("abt_count", ev_cyc_q.size(), 2);
    if (ev_cyc_q.size() == 2) chk("abt_gap", busy_fall - ev_cyc_q[1], 3);
    chk("abt_ovf", 32'(bus.overflow), 32'd0);
    chk("abt_left", exp_q.size(), 0);

    // Reset during the hold of 'A': outputs clear at once, no release follows
    ev_cyc_q.delete();
    exp_q.push_back('{press: 1'b1, code: 8'h1C});
    send(8'h41);
    wait_events("mid", 1, 50);
    reset = 1'b1;
    #1;
    chk("mid_ps2", 32'(bus.ps2_key), 32'd0);
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_ovf", 32'(bus.overflow), 32'd0);
    chk("mid_wait", 32'(bus.input_wait), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    ev_cyc_q.delete();
    expect_key(8'h32);
    send(8'h42);
    wait_idle("b", 100);
    chk("b_count", ev_cyc_q.size(), 2);
    chk("b_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
